// File: rtl/shift_reg_cfg_rx.sv
// Serial config receiver: shifts sdata into a dynamic or static chain and commits the word only
// when exactly the chain length was shifted. Commit visible 1 cycle after select drops; no backpressure.
module shift_reg_cfg_rx #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CNTW       = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sdata_i,
    input  logic                  sel_dyn_i,
    input  logic                  sel_stat_i,
    input  logic                  clr_err_i,
    output logic [SIZESRDYN-1:0]  dyn_cfg_o,
    output logic [SIZESRSTAT-1:0] stat_cfg_o,
    output logic                  dyn_upd_o,
    output logic                  stat_upd_o,
    output logic                  sdo_o,
    output logic                  busy_o,
    output logic                  err_len_o,
    output logic                  err_sel_o
);

    typedef enum logic [1:0] {IDLE, SHIFT_DYN, SHIFT_STAT, ABORT} state_e;

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] DYN_LEN  = CNTW'(SIZESRDYN);
    localparam logic [CNTW-1:0] STAT_LEN = CNTW'(SIZESRSTAT);

    state_e                  state_q, state_d;
    logic [SIZESRDYN-1:0]    dyn_q, dyn_d;
    logic [SIZESRSTAT-1:0]   stat_q, stat_d;
    logic [CNTW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [SIZESRDYN-1:0]    dyn_cfg_q, dyn_cfg_d;
    logic [SIZESRSTAT-1:0]   stat_cfg_q, stat_cfg_d;
    logic                    dyn_upd_q, dyn_upd_d;
    logic                    stat_upd_q, stat_upd_d;
    logic                    err_len_q, err_len_d;
    logic                    err_sel_q, err_sel_d;
    logic                    set_len, set_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dyn_q      <= '0;
            stat_q     <= '0;
            cnt_q      <= '0;
            dyn_cfg_q  <= '0;
            stat_cfg_q <= '0;
            dyn_upd_q  <= 1'b0;
            stat_upd_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dyn_q      <= dyn_d;
            stat_q     <= stat_d;
            cnt_q      <= cnt_d;
            dyn_cfg_q  <= dyn_cfg_d;
            stat_cfg_q <= stat_cfg_d;
            dyn_upd_q  <= dyn_upd_d;
            stat_upd_q <= stat_upd_d;
            err_len_q  <= err_len_d;
            err_sel_q  <= err_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sel_dyn_i && sel_stat_i) state_d = ABORT;
                else if (sel_dyn_i)          state_d = SHIFT_DYN;
                else if (sel_stat_i)         state_d = SHIFT_STAT;
            end
            SHIFT_DYN: begin
                if (sel_stat_i)      state_d = ABORT;
                else if (!sel_dyn_i) state_d = IDLE;
            end
            SHIFT_STAT: begin
                if (sel_dyn_i)        state_d = ABORT;
                else if (!sel_stat_i) state_d = IDLE;
            end
            ABORT: begin
                if (!sel_dyn_i && !sel_stat_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        dyn_d      = dyn_q;
        stat_d     = stat_q;
        cnt_d      = cnt_q;
        dyn_cfg_d  = dyn_cfg_q;
        stat_cfg_d = stat_cfg_q;
        dyn_upd_d  = 1'b0;
        stat_upd_d = 1'b0;
        set_len    = 1'b0;
        set_sel    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_dyn_i && sel_stat_i) begin
                    set_sel = 1'b1;
                end else if (sel_dyn_i) begin
                    dyn_d = {{(SIZESRDYN-1){1'b0}}, sdata_i};
                    cnt_d = CNTW'(1);
                end else if (sel_stat_i) begin
                    stat_d = {{(SIZESRSTAT-1){1'b0}}, sdata_i};
                    cnt_d  = CNTW'(1);
                end
            end
            SHIFT_DYN: begin
                if (sel_stat_i) begin
                    set_sel = 1'b1;
                end else if (sel_dyn_i) begin
                    dyn_d = {dyn_q[SIZESRDYN-2:0], sdata_i};
                    cnt_d = cnt_inc;
                end else if (cnt_q == DYN_LEN) begin
                    dyn_cfg_d = dyn_q;
                    dyn_upd_d = 1'b1;
                end else begin
                    set_len = 1'b1;
                end
            end
            SHIFT_STAT: begin
                if (sel_dyn_i) begin
                    set_sel = 1'b1;
                end else if (sel_stat_i) begin
                    stat_d = {stat_q[SIZESRSTAT-2:0], sdata_i};
                    cnt_d  = cnt_inc;
                end else if (cnt_q == STAT_LEN) begin
                    stat_cfg_d = stat_q;
                    stat_upd_d = 1'b1;
                end else begin
                    set_len = 1'b1;
                end
            end
            default: ;
        endcase
        // Setting an error wins over a simultaneous clear.
        err_len_d = set_len | (err_len_q & ~clr_err_i);
        err_sel_d = set_sel | (err_sel_q & ~clr_err_i);
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        sdo_o  = 1'b0;
        if (state_q == SHIFT_DYN)  sdo_o = dyn_q[SIZESRDYN-1];
        if (state_q == SHIFT_STAT) sdo_o = stat_q[SIZESRSTAT-1];
    end

    assign dyn_cfg_o  = dyn_cfg_q;
    assign stat_cfg_o = stat_cfg_q;
    assign dyn_upd_o  = dyn_upd_q;
    assign stat_upd_o = stat_upd_q;
    assign err_len_o  = err_len_q;
    assign err_sel_o  = err_sel_q;

endmodule

// File: tb/tb_shift_reg_cfg_rx.sv
// Directed bench for shift_reg_cfg_rx: frames, length/select errors, mid-frame reset, sdo.
module tb_shift_reg_cfg_rx;

    logic         clk = 1'b0;
    logic         rst, sdata, sel_dyn, sel_stat, clr_err;
    logic [15:0]  dyn_cfg;
    logic [87:0]  stat_cfg;
    logic         dyn_upd, stat_upd, sdo, busy, err_len, err_sel;
    int           n_chk = 0;
    int           n_err = 0;

    shift_reg_cfg_rx #(.SIZESRSTAT(88), .SIZESRDYN(16), .CNTW(8)) dut (
        .clk_i(clk), .rst_i(rst), .sdata_i(sdata), .sel_dyn_i(sel_dyn),
        .sel_stat_i(sel_stat), .clr_err_i(clr_err),
        .dyn_cfg_o(dyn_cfg), .stat_cfg_o(stat_cfg), .dyn_upd_o(dyn_upd),
        .stat_upd_o(stat_upd), .sdo_o(sdo), .busy_o(busy),
        .err_len_o(err_len), .err_sel_o(err_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift n bits of v, MSB first, on the chosen chain; select stays high afterwards.
    task automatic shift_bits(input logic [127:0] v, input int n, input bit is_dyn);
        for (int i = n - 1; i >= 0; i--) begin
            sdata    = v[i];
            sel_dyn  = is_dyn;
            sel_stat = !is_dyn;
            tick();
        end
    endtask

    task automatic end_frame();
        sel_dyn  = 1'b0;
        sel_stat = 1'b0;
        sdata    = 1'b0;
        tick();
    endtask

    initial begin
        logic [87:0] alt;
        alt      = {44{2'b10}};
        rst      = 1'b1;
        sdata    = 1'b0;
        sel_dyn  = 1'b0;
        sel_stat = 1'b0;
        clr_err  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dyn_cfg", dyn_cfg, 0);
        chk("rst_stat_cfg", stat_cfg, 0);
        chk("rst_flags", {dyn_upd, stat_upd, sdo, busy, err_len, err_sel}, 0);

        // 0x8001 frame; sdo follows the chain MSB
        shift_bits(128'h8001, 1, 1'b1);
        chk("sdo_edge1", sdo, 0);
        chk("busy_shift", busy, 1);
        shift_bits(128'h0001, 15, 1'b1);
        chk("sdo_edge16", sdo, 1);
        chk("no_early_upd", dyn_upd, 0);
        end_frame();
        chk("dyn_8001", dyn_cfg, 16'h8001);
        chk("dyn_upd_pulse", dyn_upd, 1);
        chk("err_len_ok", err_len, 0);
        chk("sdo_idle", {sdo, busy}, 0);
        tick();
        chk("dyn_upd_1cyc", dyn_upd, 0);

        // 88-bit static frame 1010...
        shift_bits({40'h0, alt}, 88, 1'b0);
        end_frame();
        chk("stat_aa", stat_cfg, {40'h0, alt});
        chk("stat_upd_pulse", stat_upd, 1);
        chk("dyn_kept_stat", dyn_cfg, 16'h8001);
        tick();
        chk("stat_upd_1cyc", stat_upd, 0);

        // short frame
        shift_bits(128'h7FFF, 15, 1'b1);
        end_frame();
        chk("len15_err", err_len, 1);
        chk("len15_noupd", dyn_upd, 0);
        chk("len15_keep", dyn_cfg, 16'h8001);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("len_clr", err_len, 0);

        // long frame, clear asserted on the failing commit: set wins
        shift_bits(128'h1FFFF, 17, 1'b1);
        clr_err = 1'b1;
        end_frame();
        clr_err = 1'b0;
        chk("len17_err_prio", err_len, 1);
        chk("len17_keep", {dyn_upd, dyn_cfg}, {1'b0, 16'h8001});
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("len17_clr", err_len, 0);

        // select conflict at bit 8 of a dyn frame
        shift_bits(128'h55, 8, 1'b1);
        sel_stat = 1'b1;
        tick();
        chk("abort_err_sel", err_sel, 1);
        chk("abort_busy", busy, 1);
        sel_stat = 1'b0;
        shift_bits(128'hFF, 8, 1'b1);
        chk("abort_hold", {busy, sdo}, 2'b10);
        end_frame();
        chk("abort_exit", {busy, dyn_upd, err_len}, 0);
        chk("abort_nocommit", dyn_cfg, 16'h8001);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("sel_clr", err_sel, 0);
        shift_bits(128'hBEEF, 16, 1'b1);
        end_frame();
        chk("after_abort", {dyn_upd, dyn_cfg}, {1'b1, 16'hBEEF});

        // both selects in IDLE
        sel_dyn  = 1'b1;
        sel_stat = 1'b1;
        tick();
        chk("idle_both", {err_sel, busy}, 2'b11);
        end_frame();
        chk("idle_both_exit", {busy, dyn_cfg}, {1'b0, 16'hBEEF});

        // reset at bit 10 of a dyn frame
        shift_bits(128'hFFFF, 10, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_cfg", {dyn_cfg, stat_cfg}, 0);
        chk("midrst_flags", {dyn_upd, stat_upd, sdo, busy, err_len, err_sel}, 0);
        rst = 1'b0;
        end_frame();
        shift_bits(128'h1234, 16, 1'b1);
        end_frame();
        chk("dyn_1234", dyn_cfg, 16'h1234);
        chk("dyn_1234_upd", dyn_upd, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
